// File: rtl/elevator_control_4floors.sv
// Four-floor collective elevator controller: latches calls, sweeps in one direction
// serving every call ahead before reversing, and dwells at each served floor.
module elevator_control_4floors #(
  parameter int FLOOR_CYCLES = 1,
  parameter int DOOR_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] request,
  output logic [1:0] current_floor,
  output logic       moving
);

  localparam int CW = 16;
  localparam logic [CW-1:0] FLOOR_LAST = CW'(FLOOR_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LAST  = CW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;

  state_t        state, state_nxt;
  logic [3:0]    pend, pend_nxt, calls, served;
  logic          last_up, last_up_nxt;
  logic [1:0]    floor_nxt, arrive_floor;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          moving_nxt;
  logic          ahead_here, behind_here, ahead_arrive;

  function automatic logic calls_above(input logic [3:0] c, input logic [1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++)
      if (i > int'(f)) r = r | c[i];
    return r;
  endfunction

  function automatic logic calls_below(input logic [3:0] c, input logic [1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++)
      if (i < int'(f)) r = r | c[i];
    return r;
  endfunction

  function automatic logic [3:0] floor_bit(input logic [1:0] f);
    return 4'b0001 << f;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      current_floor <= 2'd0;
      moving        <= 1'b0;
      pend          <= 4'b0;
      cnt           <= '0;
      last_up       <= 1'b1;
    end else begin
      state         <= state_nxt;
      current_floor <= floor_nxt;
      moving        <= moving_nxt;
      pend          <= pend_nxt;
      cnt           <= cnt_nxt;
      last_up       <= last_up_nxt;
    end
  end

  // Calls pressed this very edge count as pending, so a car arriving can stop for them.
  always_comb begin
    calls        = pend | request;
    state_nxt    = state;
    floor_nxt    = current_floor;
    cnt_nxt      = cnt;
    last_up_nxt  = last_up;
    served       = 4'b0;
    ahead_here   = last_up ? calls_above(calls, current_floor) : calls_below(calls, current_floor);
    behind_here  = last_up ? calls_below(calls, current_floor) : calls_above(calls, current_floor);
    arrive_floor = (state == UP) ? current_floor + 2'd1 : current_floor - 2'd1;
    ahead_arrive = (state == UP) ? calls_above(calls, arrive_floor)
                                 : calls_below(calls, arrive_floor);

    case (state)
      IDLE: begin
        if (calls[current_floor]) begin
          state_nxt = DOOR;
          served    = floor_bit(current_floor);
          cnt_nxt   = '0;
        end else if (ahead_here) begin
          state_nxt = last_up ? UP : DOWN;
          cnt_nxt   = '0;
        end else if (behind_here) begin
          state_nxt   = last_up ? DOWN : UP;
          last_up_nxt = ~last_up;
          cnt_nxt     = '0;
        end
      end
      UP, DOWN: begin
        if (cnt != FLOOR_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          floor_nxt = arrive_floor;
          cnt_nxt   = '0;
          if (calls[arrive_floor]) begin
            state_nxt = DOOR;
            served    = floor_bit(arrive_floor);
          end else if (!ahead_arrive) begin
            state_nxt = IDLE;
          end
        end
      end
      DOOR: begin
        // A fresh call for this floor holds the door open for a full new dwell.
        if (calls[current_floor]) begin
          served  = floor_bit(current_floor);
          cnt_nxt = '0;
        end else if (cnt != DOOR_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          cnt_nxt = '0;
          if (ahead_here) begin
            state_nxt = last_up ? UP : DOWN;
          end else if (behind_here) begin
            state_nxt   = last_up ? DOWN : UP;
            last_up_nxt = ~last_up;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    pend_nxt   = calls & ~served;
    moving_nxt = (state_nxt == UP) || (state_nxt == DOWN);
  end

endmodule

// File: tb/tb_elevator_control_4floors.sv
// Scenario bench for elevator_control_4floors: each task queues per-edge requests and
// the expected {floor, moving} after that edge, then replays and checks them.
module tb_elevator_control_4floors;

  logic       clk;
  logic       reset;
  logic [3:0] request;
  logic [1:0] current_floor;
  logic       moving;

  int n_cmp;
  int n_fail;

  logic [3:0] req_q[$];
  logic [2:0] exp_q[$];

  elevator_control_4floors #(.FLOOR_CYCLES(1), .DOOR_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .request(request),
    .current_floor(current_floor),
    .moving(moving)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input logic [3:0] r, input logic [1:0] f, input logic m);
    req_q.push_back(r);
    exp_q.push_back({f, m});
  endtask

  task automatic test_reset;
    reset   = 1'b0;
    request = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({current_floor, moving} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: floor=%0d moving=%0b, expected floor=0 moving=0", current_floor, moving);
    end
    n_cmp++;
    if (dut.pend !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_pend: pend=%b, expected 0000", dut.pend);
    end
    @(negedge clk);
    reset   = 1'b1;
    request = 4'b0;
    for (int i = 0; i < 3; i++) push(4'b0000, 2'd0, 1'b0);
    for (int step = 0; exp_q.size() != 0; step++) begin
      logic [2:0] e;
      request = req_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({current_floor, moving} !== e) begin
        n_fail++;
        $display("FAIL reset_idle step %0d: floor=%0d moving=%0b, expected floor=%0d moving=%0b",
                 step, current_floor, moving, e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_up_two;
    push(4'b0100, 2'd0, 1'b1);
    push(4'b0000, 2'd1, 1'b1);
    push(4'b0000, 2'd2, 1'b0);
    push(4'b0000, 2'd2, 1'b0);
    push(4'b0000, 2'd2, 1'b0);
    push(4'b0000, 2'd2, 1'b0);
    for (int step = 0; exp_q.size() != 0; step++) begin
      logic [2:0] e;
      request = req_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({current_floor, moving} !== e) begin
        n_fail++;
        $display("FAIL up_two step %0d: floor=%0d moving=%0b, expected floor=%0d moving=%0b",
                 step, current_floor, moving, e[2:1], e[0]);
      end
    end
    request = 4'b0;
    n_cmp++;
    if (dut.pend !== 4'b0) begin
      n_fail++;
      $display("FAIL up_two_pend: pend=%b, expected 0000", dut.pend);
    end
  endtask

  task automatic test_to_top;
    push(4'b1000, 2'd2, 1'b1);
    for (int i = 0; i < 5; i++) push(4'b0000, 2'd3, 1'b0);
    for (int step = 0; exp_q.size() != 0; step++) begin
      logic [2:0] e;
      request = req_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({current_floor, moving} !== e) begin
        n_fail++;
        $display("FAIL to_top step %0d: floor=%0d moving=%0b, expected floor=%0d moving=%0b",
                 step, current_floor, moving, e[2:1], e[0]);
      end
    end
    request = 4'b0;
  endtask

  task automatic test_down;
    push(4'b0001, 2'd3, 1'b1);
    push(4'b0000, 2'd2, 1'b1);
    push(4'b0000, 2'd1, 1'b1);
    for (int i = 0; i < 4; i++) push(4'b0000, 2'd0, 1'b0);
    for (int step = 0; exp_q.size() != 0; step++) begin
      logic [2:0] e;
      request = req_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({current_floor, moving} !== e) begin
        n_fail++;
        $display("FAIL down step %0d: floor=%0d moving=%0b, expected floor=%0d moving=%0b",
                 step, current_floor, moving, e[2:1], e[0]);
      end
    end
    request = 4'b0;
  endtask

  task automatic test_two_stops;
    push(4'b1010, 2'd0, 1'b1);
    push(4'b0000, 2'd1, 1'b0);
    push(4'b0000, 2'd1, 1'b0);
    push(4'b0000, 2'd1, 1'b1);
    push(4'b0000, 2'd2, 1'b1);
    push(4'b0000, 2'd3, 1'b0);
    push(4'b0000, 2'd3, 1'b0);
    push(4'b0000, 2'd3, 1'b0);
    for (int step = 0; exp_q.size() != 0; step++) begin
      logic [2:0] e;
      request = req_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({current_floor, moving} !== e) begin
        n_fail++;
        $display("FAIL two_stops step %0d: floor=%0d moving=%0b, expected floor=%0d moving=%0b",
                 step, current_floor, moving, e[2:1], e[0]);
      end
    end
    request = 4'b0;
    n_cmp++;
    if (dut.pend !== 4'b0) begin
      n_fail++;
      $display("FAIL two_stops_pend: pend=%b, expected 0000", dut.pend);
    end
  endtask

  // Down sweep serves 2 then 0; a call for 3 made while passing 2 waits for the up sweep.
  task automatic test_sweep;
    push(4'b0101, 2'd3, 1'b1);
    push(4'b0000, 2'd2, 1'b0);
    push(4'b0000, 2'd2, 1'b0);
    push(4'b0000, 2'd2, 1'b1);
    push(4'b1000, 2'd1, 1'b1);
    push(4'b0000, 2'd0, 1'b0);
    push(4'b0000, 2'd0, 1'b0);
    push(4'b0000, 2'd0, 1'b1);
    push(4'b0000, 2'd1, 1'b1);
    push(4'b0000, 2'd2, 1'b1);
    push(4'b0000, 2'd3, 1'b0);
    push(4'b0000, 2'd3, 1'b0);
    push(4'b0000, 2'd3, 1'b0);
    for (int step = 0; exp_q.size() != 0; step++) begin
      logic [2:0] e;
      request = req_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({current_floor, moving} !== e) begin
        n_fail++;
        $display("FAIL sweep step %0d: floor=%0d moving=%0b, expected floor=%0d moving=%0b",
                 step, current_floor, moving, e[2:1], e[0]);
      end
    end
    request = 4'b0;
  endtask

  task automatic test_down_to_one;
    push(4'b0010, 2'd3, 1'b1);
    push(4'b0000, 2'd2, 1'b1);
    push(4'b0000, 2'd1, 1'b0);
    push(4'b0000, 2'd1, 1'b0);
    push(4'b0000, 2'd1, 1'b0);
    for (int step = 0; exp_q.size() != 0; step++) begin
      logic [2:0] e;
      request = req_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({current_floor, moving} !== e) begin
        n_fail++;
        $display("FAIL down_to_one step %0d: floor=%0d moving=%0b, expected floor=%0d moving=%0b",
                 step, current_floor, moving, e[2:1], e[0]);
      end
    end
    request = 4'b0;
  endtask

  // Call at the current floor opens the door in place; a repeat press restarts the dwell.
  task automatic test_door_here;
    push(4'b0010, 2'd1, 1'b0);
    push(4'b0010, 2'd1, 1'b0);
    push(4'b0100, 2'd1, 1'b0);
    push(4'b0000, 2'd1, 1'b1);
    push(4'b0000, 2'd2, 1'b0);
    push(4'b0000, 2'd2, 1'b0);
    push(4'b0000, 2'd2, 1'b0);
    for (int step = 0; exp_q.size() != 0; step++) begin
      logic [2:0] e;
      request = req_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({current_floor, moving} !== e) begin
        n_fail++;
        $display("FAIL door_here step %0d: floor=%0d moving=%0b, expected floor=%0d moving=%0b",
                 step, current_floor, moving, e[2:1], e[0]);
      end
    end
    request = 4'b0;
  endtask

  task automatic test_reset_mid_travel;
    push(4'b0001, 2'd2, 1'b1);
    push(4'b0000, 2'd1, 1'b1);
    for (int step = 0; exp_q.size() != 0; step++) begin
      logic [2:0] e;
      request = req_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({current_floor, moving} !== e) begin
        n_fail++;
        $display("FAIL mid_travel_pre step %0d: floor=%0d moving=%0b, expected floor=%0d moving=%0b",
                 step, current_floor, moving, e[2:1], e[0]);
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({current_floor, moving} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: floor=%0d moving=%0b, expected floor=0 moving=0", current_floor, moving);
    end
    request = 4'b1111;
    @(posedge clk); #1;
    n_cmp++;
    if (dut.pend !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_pend_held: pend=%b, expected 0000", dut.pend);
    end
    @(negedge clk);
    reset   = 1'b1;
    request = 4'b0;
    for (int i = 0; i < 4; i++) push(4'b0000, 2'd0, 1'b0);
    for (int step = 0; exp_q.size() != 0; step++) begin
      logic [2:0] e;
      request = req_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({current_floor, moving} !== e) begin
        n_fail++;
        $display("FAIL post_reset_idle step %0d: floor=%0d moving=%0b, expected floor=%0d moving=%0b",
                 step, current_floor, moving, e[2:1], e[0]);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    reset   = 1'b0;
    request = 4'b0;
    test_reset();
    test_up_two();
    test_to_top();
    test_down();
    test_two_stops();
    test_sweep();
    test_down_to_one();
    test_door_here();
    test_reset_mid_travel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
